// File: rtl/arith_pkg.sv
// Shared types and helpers for the digit-serial arithmetic blocks.
package arith_pkg;

    // Sequencer states of the digit-serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Step-counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned steps);
        int unsigned w;
        w = clog2(steps);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/digit_fa.sv
// Combinational ripple of DIGIT full-adder cells.
module digit_fa #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // c[i] is the carry into cell i; c[DIGIT] leaves the top cell.
    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin, DIGIT bits per clock, valid/ready on both sides.
module digit_serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    // Reject illegal geometries at elaboration.
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  fa_s;
    logic              fa_co;
    logic              fa_c_msb;
    logic [WIDTH-1:0]  sum_shift;

    digit_fa #(
        .DIGIT (DIGIT)
    ) u_digit_fa (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (fa_s),
        .co    (fa_co),
        .c_msb (fa_c_msb)
    );

    // New digit enters at the MSB end so the last digit lands in the top bits.
    if (DIGIT == WIDTH) begin : g_sum_whole
        assign sum_shift = fa_s;
    end else begin : g_sum_shift
        assign sum_shift = {fa_s, sum_q[WIDTH-1:DIGIT]};
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                sum_d   = sum_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = fa_co;
                    // Signed overflow: carry into MSB differs from carry out of MSB.
                    ovf_d   = fa_c_msb ^ fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and exhaustive checks of digit_serial_adder at three geometries.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 8-bit, 2-bit digit instance.
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;
    logic       busy;

    // Shared stimulus for the two 4-bit instances.
    logic       iv4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       c4 = 1'b0;
    logic       or4 = 1'b0;

    logic       ir_d1, ov_d1, co_d1, of_d1, bz_d1;
    logic [3:0] s_d1;
    logic       ir_d4, ov_d4, co_d4, of_d4, bz_d4;
    logic [3:0] s_d4;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .overflow(overflow), .busy(busy)
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4d1 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir_d1), .a(a4), .b(b4),
        .cin(c4), .out_valid(ov_d1), .out_ready(or4), .sum(s_d1), .cout(co_d1),
        .overflow(of_d1), .busy(bz_d1)
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut4d4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir_d4), .a(a4), .b(b4),
        .cin(c4), .out_valid(ov_d4), .out_ready(or4), .sum(s_d4), .cout(co_d4),
        .overflow(of_d4), .busy(bz_d4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the 8-bit instance, leave it in DONE with out_ready low.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 99;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    // Complete the handshake and confirm return to IDLE.
    task automatic release8(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ir_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int sa, sb, t;
        logic [4:0] ref5;
        logic       ref_ovf;
        logic       seen;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // FF + 01: wraps to zero with carry-out, no signed overflow.
        run8(8'hFF, 8'h01, 1'b0, lat);
        check("ff01_lat", lat, 32'd4);
        check("ff01_sum", {24'd0, sum}, 32'h00);
        check("ff01_cout", {31'd0, cout}, 32'd1);
        check("ff01_ovf", {31'd0, overflow}, 32'd0);
        check("ff01_busy", {31'd0, busy}, 32'd1);
        check("ff01_ir", {31'd0, in_ready}, 32'd0);
        release8("ff01");

        // 7F + 01: positive overflow into the sign bit.
        run8(8'h7F, 8'h01, 1'b0, lat);
        check("7f01_lat", lat, 32'd4);
        check("7f01_sum", {24'd0, sum}, 32'h80);
        check("7f01_cout", {31'd0, cout}, 32'd0);
        check("7f01_ovf", {31'd0, overflow}, 32'd1);
        release8("7f01");

        // 80 + 80: negative overflow with carry-out.
        run8(8'h80, 8'h80, 1'b0, lat);
        check("8080_sum", {24'd0, sum}, 32'h00);
        check("8080_cout", {31'd0, cout}, 32'd1);
        check("8080_ovf", {31'd0, overflow}, 32'd1);
        release8("8080");

        // Backpressure: result held while out_ready is low, new requests ignored.
        run8(8'h12, 8'h34, 1'b0, lat);
        check("bp_lat", lat, 32'd4);
        for (int k = 0; k < 5; k++) begin
            a        = 8'h11;
            b        = 8'h11;
            in_valid = (k % 2) == 0;
            tick();
            check("bp_ov_hold", {31'd0, out_valid}, 32'd1);
            check("bp_sum_hold", {24'd0, sum}, 32'h46);
            check("bp_ir_low", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release8("bp");
        run8(8'h05, 8'h0A, 1'b1, lat);
        check("bp_next_lat", lat, 32'd4);
        check("bp_next_sum", {24'd0, sum}, 32'h10);
        check("bp_next_cout", {31'd0, cout}, 32'd0);
        release8("bp_next");

        // Reset during the second RUN cycle abandons the operation.
        a        = 8'h33;
        b        = 8'h44;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ir", {31'd0, in_ready}, 32'd1);
        check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_sum", {24'd0, sum}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_ov", {31'd0, seen}, 32'd0);

        // Carry-in alone.
        run8(8'h00, 8'h00, 1'b1, lat);
        check("cin_sum", {24'd0, sum}, 32'h01);
        check("cin_cout", {31'd0, cout}, 32'd0);
        check("cin_ovf", {31'd0, overflow}, 32'd0);
        release8("cin");

        // Exhaustive 4-bit sweep, bit-serial and single-step instances side by side.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v   = 9'(i);
            a4  = v[8:5];
            b4  = v[4:1];
            c4  = v[0];
            ref5 = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
            sa = a4[3] ? int'(a4) - 16 : int'(a4);
            sb = b4[3] ? int'(b4) - 16 : int'(b4);
            t  = sa + sb + int'(c4);
            ref_ovf = (t > 7) || (t < -8);
            iv4 = 1'b1;
            tick();
            iv4 = 1'b0;
            for (int n = 0; n < 12; n++) begin
                tick();
                if (ov_d1 && ov_d4) break;
            end
            check("ex_d1_valid", {31'd0, ov_d1}, 32'd1);
            check("ex_d4_valid", {31'd0, ov_d4}, 32'd1);
            check("ex_d1_sum", {27'd0, co_d1, s_d1}, {27'd0, ref5});
            check("ex_d4_sum", {27'd0, co_d4, s_d4}, {27'd0, ref5});
            check("ex_d1_ovf", {31'd0, of_d1}, {31'd0, ref_ovf});
            check("ex_d4_ovf", {31'd0, of_d4}, {31'd0, ref_ovf});
            or4 = 1'b1;
            tick();
            or4 = 1'b0;
            if (i == 511) begin
                check("ex_idle_ir", {30'd0, ir_d1, ir_d4}, 32'd3);
                check("ex_idle_busy", {30'd0, bz_d1, bz_d4}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a wait somehow stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
